levelsync_sr_vec: RTL and testbench
===================================

LEVELSYNC_SR_VEC -- requirements
Module: levelsync_sr_vec

Interface
REQ-001 Parameter: WIDTH, default 1, number of independent single-bit level channels (>=1).
REQ-002 Parameter: SYNC_STAGES, default 2, flops per synchroniser chain (2..4).
REQ-003 Parameter: FILTER_CYCLES, default 0, stability window in clk_dest cycles; 0 disables the filter (0..255).
REQ-004 Parameter: RESET_VALUE, default all-zero, WIDTH-bit value loaded by reset.
REQ-005 Parameter: SET_VALUE, default all-ones, WIDTH-bit value loaded by set.
REQ-006 Port: clk_dest  input  1  destination clock, the single clock of the block.
REQ-007 Port: rst_dest_n  input  1  asynchronous active-low reset.
REQ-008 Port: set_dest_n  input  1  asynchronous active-low set.
REQ-009 Port: src_data  input  WIDTH  asynchronous level inputs, one per channel.
REQ-010 Port: dest_data  output  WIDTH  synchronised, filtered levels.
REQ-011 Port: dest_rise  output  WIDTH  per-channel one-cycle pulse on a dest_data 0->1 change.
REQ-012 Port: dest_fall  output  WIDTH  per-channel one-cycle pulse on a dest_data 1->0 change.
REQ-013 Port: dest_chg  output  1  OR of all dest_rise and dest_fall bits.
REQ-014 Out-of-range parameters SHALL cause an elaboration error.

Function
REQ-015 Each channel SHALL be fully independent; no cross-bit coherency is guaranteed.
REQ-016 Each channel SHALL sample src_data[i] into stage 0 and shift through SYNC_STAGES flops; the last stage is the synced value.
REQ-017 Stage 0 flops SHALL carry the AsYnCiNpUt_ prefix so timing and DFT scripts can locate them.
REQ-018 FILTER_CYCLES=0: dest_data[i] SHALL equal the synced value; latency is SYNC_STAGES clk_dest edges.
REQ-019 FILTER_CYCLES=F>0: each channel SHALL hold a filtered bit filt[i] and a counter cnt[i] of width clog2(F+1).
REQ-020 Each edge with synced == filt[i]: cnt[i] SHALL clear to 0.
REQ-021 Each edge with synced != filt[i] and cnt[i] < F-1: cnt[i] SHALL increment.
REQ-022 Each edge with synced != filt[i] and cnt[i] == F-1: filt[i] SHALL take the synced value and cnt[i] SHALL clear.
REQ-023 A synced pulse shorter than F cycles SHALL never reach dest_data; a change that is stable for F cycles SHALL appear SYNC_STAGES+F edges after src_data changes.
REQ-024 The counter SHALL never exceed F-1; no wrap-around is permitted.
REQ-025 dest_data SHALL be driven directly from flops (filt[i], or the last sync stage when F=0).
REQ-026 A registered copy dest_q SHALL track dest_data with one cycle of delay; dest_rise = dest_data & ~dest_q and dest_fall = ~dest_data & dest_q.
REQ-027 Edge pulses SHALL therefore occur in the first cycle dest_data shows the new value and last exactly one cycle.

Reset
REQ-028 rst_dest_n low SHALL immediately load all sync stages, filt and dest_q with RESET_VALUE, and clear every cnt, independent of clk_dest.
REQ-029 set_dest_n low with rst_dest_n high SHALL immediately load all sync stages, filt and dest_q with SET_VALUE, and clear every cnt.
REQ-030 When both are low, reset SHALL win.
REQ-031 During and directly after reset or set, dest_rise, dest_fall and dest_chg SHALL be 0; dest_data SHALL equal the loaded value.
REQ-032 Reset or set asserted mid-filter-count SHALL discard the pending change.

Verification
Use WIDTH=4, SYNC_STAGES=2, FILTER_CYCLES=3, RESET_VALUE=4'h0, SET_VALUE=4'hA.
REQ-033 Reset released with src_data=4'h0, then src_data=4'h1 held -> dest_data=4'h1 at edge 5, dest_rise=4'h1 and dest_chg=1 for exactly that cycle.
REQ-034 src_data[2] high for 2 cycles then low -> dest_data[2] stays 0; no rise or fall pulse.
REQ-035 set_dest_n pulsed low -> dest_data=4'hA asynchronously, no pulses; with src_data=4'h0 held after release, dest_data=4'h0 5 edges later and dest_fall=4'hA for one cycle.
REQ-036 rst_dest_n and set_dest_n both low -> dest_data=4'h0; releasing rst_dest_n first -> dest_data=4'hA.
REQ-037 rst_dest_n asserted while cnt[0]=2 -> after release the channel restarts from 0 and the pending change is not emitted early.
REQ-038 FILTER_CYCLES=0 build, src_data=4'hF from reset -> dest_data=4'hF after 2 edges, dest_rise=4'hF for one cycle.

Source files
------------

// File: rtl/levelsync_sr_vec.sv
// -----------------------------------------------------------------------------
// levelsync_sr_vec
//
// Brings WIDTH independent asynchronous level signals into the clk_dest domain.
// Each channel runs through its own SYNC_STAGES-deep synchroniser, an optional
// glitch filter that only accepts a new level after it has been stable for
// FILTER_CYCLES destination edges, and an edge detector producing one-cycle
// rise/fall pulses. Channels are independent: no cross-bit coherency.
//
// Ports
//   clk_dest    in   1      destination clock (only clock of the block)
//   rst_dest_n  in   1      asynchronous active-low reset (wins over set)
//   set_dest_n  in   1      asynchronous active-low set
//   src_data    in   WIDTH  asynchronous level inputs
//   dest_data   out  WIDTH  synchronised, filtered levels (straight from flops)
//   dest_rise   out  WIDTH  one-cycle pulse on a dest_data 0->1 change
//   dest_fall   out  WIDTH  one-cycle pulse on a dest_data 1->0 change
//   dest_chg    out  1      OR of every dest_rise and dest_fall bit
// -----------------------------------------------------------------------------
module levelsync_sr_vec #(
  parameter int               WIDTH         = 1,
  parameter int               SYNC_STAGES   = 2,
  parameter int               FILTER_CYCLES = 0,
  parameter logic [WIDTH-1:0] RESET_VALUE   = '0,
  parameter logic [WIDTH-1:0] SET_VALUE     = '1
) (
  input  logic             clk_dest,
  input  logic             rst_dest_n,
  input  logic             set_dest_n,
  input  logic [WIDTH-1:0] src_data,
  output logic [WIDTH-1:0] dest_data,
  output logic [WIDTH-1:0] dest_rise,
  output logic [WIDTH-1:0] dest_fall,
  output logic             dest_chg
);

  // ---------------------------------------------------------------------------
  // Parameter range checks (elaboration-time)
  // ---------------------------------------------------------------------------
  if (WIDTH < 1) begin : g_bad_width
    $error("levelsync_sr_vec: WIDTH must be >= 1");
  end
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_stages
    $error("levelsync_sr_vec: SYNC_STAGES must be in 2..4");
  end
  if (FILTER_CYCLES < 0 || FILTER_CYCLES > 255) begin : g_bad_filter
    $error("levelsync_sr_vec: FILTER_CYCLES must be in 0..255");
  end

  // ---------------------------------------------------------------------------
  // Synchroniser chains. Stage 0 keeps the AsYnCiNpUt_ prefix so timing and
  // DFT scripts can find the flops that capture the asynchronous inputs.
  // r_sync_tail[k] is synchroniser stage k+1.
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] AsYnCiNpUt_r_sync0;
  logic [WIDTH-1:0] r_sync_tail [SYNC_STAGES-1];
  logic [WIDTH-1:0] w_synced;
  logic [WIDTH-1:0] w_dest;

  // NOTE: every register in this block uses non-blocking assignments so all
  // stages sample the pre-edge values together and the chain really shifts.
  always_ff @(posedge clk_dest or negedge rst_dest_n or negedge set_dest_n) begin
    if (!rst_dest_n) begin
      AsYnCiNpUt_r_sync0 <= RESET_VALUE;
      // NOTE: the stage array is ordinary flops, not a RAM, so each entry is
      // loaded on reset/set; a stale stage would leak a bogus edge later.
      for (int k = 0; k < SYNC_STAGES - 1; k++) r_sync_tail[k] <= RESET_VALUE;
    end else if (!set_dest_n) begin
      AsYnCiNpUt_r_sync0 <= SET_VALUE;
      for (int k = 0; k < SYNC_STAGES - 1; k++) r_sync_tail[k] <= SET_VALUE;
    end else begin
      AsYnCiNpUt_r_sync0 <= src_data;
      r_sync_tail[0]     <= AsYnCiNpUt_r_sync0;
      for (int k = 1; k < SYNC_STAGES - 1; k++) r_sync_tail[k] <= r_sync_tail[k-1];
    end
  end

  assign w_synced = r_sync_tail[SYNC_STAGES-2];

  // ---------------------------------------------------------------------------
  // Stability filter. A channel's filtered bit only flips after the synced
  // value has disagreed with it on FILTER_CYCLES consecutive edges; any edge
  // where they agree restarts the count. The counter saturates at F-1 by
  // construction (reaching F-1 with a mismatch commits and clears).
  // ---------------------------------------------------------------------------
  if (FILTER_CYCLES > 0) begin : g_filter
    localparam int               CNT_W    = $clog2(FILTER_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

    logic [WIDTH-1:0] r_filt;
    logic [CNT_W-1:0] r_cnt [WIDTH];

    always_ff @(posedge clk_dest or negedge rst_dest_n or negedge set_dest_n) begin
      if (!rst_dest_n) begin
        r_filt <= RESET_VALUE;
        for (int i = 0; i < WIDTH; i++) r_cnt[i] <= '0;
      end else if (!set_dest_n) begin
        r_filt <= SET_VALUE;
        for (int i = 0; i < WIDTH; i++) r_cnt[i] <= '0;
      end else begin
        for (int i = 0; i < WIDTH; i++) begin
          if (w_synced[i] == r_filt[i]) begin
            r_cnt[i] <= '0;
          end else if (r_cnt[i] == CNT_LAST) begin
            r_filt[i] <= w_synced[i];
            r_cnt[i]  <= '0;
          end else begin
            r_cnt[i] <= r_cnt[i] + 1'b1;
          end
        end
      end
    end

    assign w_dest = r_filt;
  end else begin : g_no_filter
    assign w_dest = w_synced;
  end

  // ---------------------------------------------------------------------------
  // Edge detection against a one-cycle-delayed copy. Reset/set load the copy
  // with the same value as the data path, so no pulse follows either event.
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] r_dest_q;

  always_ff @(posedge clk_dest or negedge rst_dest_n or negedge set_dest_n) begin
    if (!rst_dest_n) begin
      r_dest_q <= RESET_VALUE;
    end else if (!set_dest_n) begin
      r_dest_q <= SET_VALUE;
    end else begin
      r_dest_q <= w_dest;
    end
  end

  assign dest_data = w_dest;
  assign dest_rise = w_dest & ~r_dest_q;
  assign dest_fall = ~w_dest & r_dest_q;
  assign dest_chg  = |(dest_rise | dest_fall);

endmodule

// File: tb/tb_levelsync_sr_vec.sv
// -----------------------------------------------------------------------------
// tb_levelsync_sr_vec
//
// Two instances share clock, reset and set: dut_f (FILTER_CYCLES=3) and dut_n
// (FILTER_CYCLES=0). A reference model tracks each channel as a sample delay
// line plus a "last F filter inputs all disagree" window rule; a compare
// process checks every output of both instances on each falling clock edge.
// Directed sequences add literal expectations worked out by hand.
// -----------------------------------------------------------------------------
module tb_levelsync_sr_vec;

  localparam int         W  = 4;
  localparam int         S  = 2;
  localparam int         F  = 3;
  localparam logic [3:0] RV = 4'h0;
  localparam logic [3:0] SV = 4'hA;

  logic       clk_dest;
  logic       rst_dest_n;
  logic       set_dest_n;
  logic [3:0] src_f, src_n;
  logic [3:0] dest_f, rise_f, fall_f;
  logic [3:0] dest_n, rise_n, fall_n;
  logic       chg_f, chg_n;

  levelsync_sr_vec #(
    .WIDTH(W), .SYNC_STAGES(S), .FILTER_CYCLES(F),
    .RESET_VALUE(RV), .SET_VALUE(SV)
  ) dut_f (
    .clk_dest  (clk_dest),
    .rst_dest_n(rst_dest_n),
    .set_dest_n(set_dest_n),
    .src_data  (src_f),
    .dest_data (dest_f),
    .dest_rise (rise_f),
    .dest_fall (fall_f),
    .dest_chg  (chg_f)
  );

  levelsync_sr_vec #(
    .WIDTH(W), .SYNC_STAGES(S), .FILTER_CYCLES(0),
    .RESET_VALUE(RV), .SET_VALUE(SV)
  ) dut_n (
    .clk_dest  (clk_dest),
    .rst_dest_n(rst_dest_n),
    .set_dest_n(set_dest_n),
    .src_data  (src_n),
    .dest_data (dest_n),
    .dest_rise (rise_n),
    .dest_fall (fall_n),
    .dest_chg  (chg_n)
  );

  initial clk_dest = 1'b0;
  always #5 clk_dest = ~clk_dest;

  int n_compared   = 0;
  int n_mismatched = 0;
  bit cmp_en       = 1'b0;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  //   m_samp : src samples still in flight through the synchroniser (oldest
  //            first); element 0 is the value the filter sees this edge.
  //   m_win  : the last F values seen by the filter; a channel flips only
  //            when all of them disagree with its current level.
  // ---------------------------------------------------------------------------
  logic [3:0] m_samp[$];
  logic [3:0] m_win[$];
  logic [3:0] m_dest, m_prev;
  logic [3:0] n_samp[$];
  logic [3:0] n_dest, n_prev;

  task automatic model_load(input logic [3:0] v);
    m_samp = {v, v};
    m_win  = {v, v, v};
    m_dest = v;
    m_prev = v;
    n_samp = {v, v};
    n_dest = v;
    n_prev = v;
  endtask

  task automatic model_edge();
    logic [3:0] seen;
    bit         all_diff;
    seen = m_samp[0];
    void'(m_samp.pop_front());
    m_samp.push_back(src_f);
    void'(m_win.pop_front());
    m_win.push_back(seen);
    m_prev = m_dest;
    for (int i = 0; i < W; i++) begin
      all_diff = 1'b1;
      foreach (m_win[j]) if (m_win[j][i] == m_prev[i]) all_diff = 1'b0;
      if (all_diff) m_dest[i] = ~m_prev[i];
    end
    n_prev = n_dest;
    void'(n_samp.pop_front());
    n_samp.push_back(src_n);
    n_dest = n_samp[0];
  endtask

  always @(posedge clk_dest or negedge rst_dest_n or negedge set_dest_n) begin
    if (!rst_dest_n)      model_load(RV);
    else if (!set_dest_n) model_load(SV);
    else                  model_edge();
  end

  always @(negedge clk_dest) begin
    if (cmp_en) begin
      check("m_dest_f", dest_f, m_dest);
      check("m_rise_f", rise_f, m_dest & ~m_prev);
      check("m_fall_f", fall_f, ~m_dest & m_prev);
      check("m_chg_f", {3'b0, chg_f}, {3'b0, |(m_dest ^ m_prev)});
      check("m_dest_n", dest_n, n_dest);
      check("m_rise_n", rise_n, n_dest & ~n_prev);
      check("m_fall_n", fall_n, ~n_dest & n_prev);
      check("m_chg_n", {3'b0, chg_n}, {3'b0, |(n_dest ^ n_prev)});
    end
  end

  // Advance to 2 time units after the next rising edge: inputs change and
  // literal checks sample here, well clear of both clock edges.
  task automatic tick();
    @(posedge clk_dest);
    #2;
  endtask

  // ---------------------------------------------------------------------------
  // Directed stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int hold;
    rst_dest_n = 1'b1;
    set_dest_n = 1'b1;
    src_f      = 4'h0;
    src_n      = 4'hF;
    #1 rst_dest_n = 1'b0;
    #1 cmp_en = 1'b1;
    check("reset_dest_f", dest_f, 4'h0);
    check("reset_chg_f", {3'b0, chg_f}, 4'h0);
    check("reset_dest_n", dest_n, 4'h0);
    repeat (2) tick();

    // Release with src=0 then hold 1 on channel 0; the unfiltered instance
    // sees 4'hF from reset.
    rst_dest_n = 1'b1;
    src_f      = 4'h1;
    for (int e = 1; e <= 6; e++) begin
      tick();
      check("lat_dest_f", dest_f, (e >= 5) ? 4'h1 : 4'h0);
      check("lat_rise_f", rise_f, (e == 5) ? 4'h1 : 4'h0);
      check("lat_chg_f", {3'b0, chg_f}, (e == 5) ? 4'h1 : 4'h0);
      check("lat_dest_n", dest_n, (e >= 2) ? 4'hF : 4'h0);
      check("lat_rise_n", rise_n, (e == 2) ? 4'hF : 4'h0);
    end

    // Two-cycle glitch on channel 2 is swallowed.
    src_f = 4'h5;
    repeat (2) tick();
    src_f = 4'h1;
    for (int e = 1; e <= 6; e++) begin
      tick();
      check("glitch_dest", dest_f, 4'h1);
      check("glitch_chg", {3'b0, chg_f}, 4'h0);
    end

    // Three-cycle pulse on channel 3 is exactly long enough to pass.
    src_f = 4'h9;
    repeat (3) tick();
    src_f = 4'h1;
    for (int e = 4; e <= 9; e++) begin
      tick();
      check("pulse3_dest", dest_f, (e >= 5 && e <= 7) ? 4'h9 : 4'h1);
    end

    // Reset mid-count: pending 0->1 change must restart from scratch.
    src_f      = 4'h0;
    rst_dest_n = 1'b0;
    tick();
    rst_dest_n = 1'b1;
    repeat (3) tick();
    src_f = 4'h1;
    repeat (4) tick();
    check("midcnt_pre", dest_f, 4'h0);
    rst_dest_n = 1'b0;
    #1;
    check("midcnt_rst", dest_f, 4'h0);
    tick();
    rst_dest_n = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      tick();
      check("midcnt_dest", dest_f, (e >= 5) ? 4'h1 : 4'h0);
      check("midcnt_rise", rise_f, (e == 5) ? 4'h1 : 4'h0);
    end

    // Asynchronous set, then fall back to the held src=0.
    src_f      = 4'h0;
    set_dest_n = 1'b0;
    #1;
    check("set_dest_f", dest_f, 4'hA);
    check("set_chg_f", {3'b0, chg_f}, 4'h0);
    check("set_fall_f", fall_f, 4'h0);
    check("set_dest_n", dest_n, 4'hA);
    tick();
    set_dest_n = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      tick();
      check("set_rel_dest", dest_f, (e >= 5) ? 4'h0 : 4'hA);
      check("set_rel_fall", fall_f, (e == 5) ? 4'hA : 4'h0);
      check("set_rel_chg", {3'b0, chg_f}, (e == 5) ? 4'h1 : 4'h0);
    end

    // Reset and set together: reset wins; releasing reset first lets set load.
    rst_dest_n = 1'b0;
    set_dest_n = 1'b0;
    #1;
    check("both_dest", dest_f, 4'h0);
    tick();
    rst_dest_n = 1'b1;
    tick();
    check("rst_first_dest", dest_f, 4'hA);
    check("rst_first_chg", {3'b0, chg_f}, 4'h0);
    set_dest_n = 1'b1;
    repeat (6) tick();

    // Mixed activity with occasional reset/set pulses; the model checks it.
    repeat (60) begin
      src_f = 4'($urandom);
      src_n = 4'($urandom);
      if ($urandom_range(0, 19) == 0) set_dest_n = 1'b0;
      if ($urandom_range(0, 19) == 0) rst_dest_n = 1'b0;
      hold = int'($urandom_range(1, 5));
      repeat (hold) begin
        tick();
        rst_dest_n = 1'b1;
        set_dest_n = 1'b1;
      end
    end
    repeat (8) tick();

    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
